// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants and types for the scanned 7-segment decoder.
// Segment patterns match the hex-to-7-segment encoder (bit0 = a).
package seg_scan_decoder_pkg;

    localparam logic [6:0] SEG_0 = 7'h3f;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5b;
    localparam logic [6:0] SEG_3 = 7'h4f;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6d;
    localparam logic [6:0] SEG_6 = 7'h7d;
    localparam logic [6:0] SEG_7 = 7'h27;
    localparam logic [6:0] SEG_8 = 7'h7f;
    localparam logic [6:0] SEG_9 = 7'h6f;
    localparam logic [6:0] SEG_A = 7'h5f;
    localparam logic [6:0] SEG_B = 7'h7c;
    localparam logic [6:0] SEG_C = 7'h58;
    localparam logic [6:0] SEG_D = 7'h5e;
    localparam logic [6:0] SEG_E = 7'h7b;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [7:0] GHOST_MAX = 8'd255;

    typedef enum logic {
        SCAN,
        HELD
    } scan_state_e;

endpackage

// File: rtl/seg_scan_decoder_seg2hex.sv
// Combinational 7-segment pattern to hex nibble lookup.
// Anything outside the 16 encoder patterns (blank included) misses.
module seg_scan_decoder_seg2hex
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nib
);

    // Strict inverse of the encoder table
    always_comb begin
        hit = 1'b1;
        nib = 4'h0;
        unique case (seg)
            SEG_0:   nib = 4'h0;
            SEG_1:   nib = 4'h1;
            SEG_2:   nib = 4'h2;
            SEG_3:   nib = 4'h3;
            SEG_4:   nib = 4'h4;
            SEG_5:   nib = 4'h5;
            SEG_6:   nib = 4'h6;
            SEG_7:   nib = 4'h7;
            SEG_8:   nib = 4'h8;
            SEG_9:   nib = 4'h9;
            SEG_A:   nib = 4'ha;
            SEG_B:   nib = 4'hb;
            SEG_C:   nib = 4'hc;
            SEG_D:   nib = 4'hd;
            SEG_E:   nib = 4'he;
            SEG_F:   nib = 4'hf;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a scanned 7-segment bus and rebuilds each digit's hex value,
// capturing a digit once its pattern has been stable long enough.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_d,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_vld,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    upd,
    output logic                    frame_done,
    output logic [7:0]              ghost_cnt
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    logic [6:0]            seg_s1;
    logic [6:0]            seg_cur;
    logic [6:0]            seg_prev;
    logic [NUM_DIGITS-1:0] an_s1;
    logic [NUM_DIGITS-1:0] an_cur;
    logic [NUM_DIGITS-1:0] an_prev;
    logic [NUM_DIGITS-1:0] sel;
    logic [NUM_DIGITS-1:0] seen;
    logic [NUM_DIGITS-1:0] seen_nxt;
    logic [7:0]            cnt;
    logic [7:0]            cnt_inc;
    scan_state_e           state;
    logic                  legal;
    logic                  same;
    logic                  capture;
    logic                  hit;
    logic [3:0]            nib;

    assign sel      = AN_ACTIVE_LOW ? ~an_cur : an_cur;
    assign legal    = (sel != '0) && ((sel & (sel - ONE)) == '0);
    assign same     = (seg_cur == seg_prev) && (an_cur == an_prev);
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
    assign capture  = legal && same && (state == SCAN) && (cnt_inc == CNT_MAX);
    assign seen_nxt = seen | sel;

    seg_scan_decoder_seg2hex u_seg2hex (
        .seg (seg_cur),
        .hit (hit),
        .nib (nib)
    );

    // Two-flop synchroniser plus one-cycle history of the bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_s1   <= '0;
            seg_cur  <= '0;
            seg_prev <= '0;
            an_s1    <= '0;
            an_cur   <= '0;
            an_prev  <= '0;
        end else begin
            seg_s1   <= seg_d;
            seg_cur  <= seg_s1;
            seg_prev <= seg_cur;
            an_s1    <= an;
            an_cur   <= an_s1;
            an_prev  <= an_cur;
        end
    end

    // Stability counter and SCAN/HELD dwell tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            state <= SCAN;
        end else if (!legal || !same) begin
            cnt   <= '0;
            state <= SCAN;
        end else begin
            cnt <= cnt_inc;
            if (capture) begin
                state <= HELD;
            end
        end
    end

    // Saturating count of samples without exactly one anode active
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghost_cnt <= '0;
        end else if (!legal && (ghost_cnt != GHOST_MAX)) begin
            ghost_cnt <= ghost_cnt + 8'd1;
        end
    end

    // Per-digit value and flags, written only for the selected digit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_out   <= '0;
            digit_vld <= '0;
            digit_err <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) begin
                    if (hit) begin
                        hex_out[4*i +: 4] <= nib;
                        digit_vld[i]      <= 1'b1;
                        digit_err[i]      <= 1'b0;
                    end else begin
                        digit_vld[i]      <= 1'b0;
                        digit_err[i]      <= 1'b1;
                    end
                end
            end
        end
    end

    // Capture pulse and frame completion; the completing capture is not
    // carried into the next frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd        <= 1'b0;
            frame_done <= 1'b0;
            seen       <= '0;
        end else begin
            upd        <= capture;
            frame_done <= capture && (&seen_nxt);
            if (capture) begin
                seen <= (&seen_nxt) ? '0 : seen_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: reference model plus
// directed scenarios with hand-computed expectations.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 4;

    localparam logic [6:0] PAT [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h27,
        7'h7f, 7'h6f, 7'h5f, 7'h7c, 7'h58, 7'h5e, 7'h7b, 7'h71
    };

    logic            clk = 1'b0;
    logic            reset_n;
    logic [6:0]      seg_d;
    logic [ND-1:0]   an;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0]   digit_vld;
    logic [ND-1:0]   digit_err;
    logic            upd;
    logic            frame_done;
    logic [7:0]      ghost_cnt;

    int tests = 0;
    int fails = 0;
    int upd_total = 0;
    int frame_total = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .NUM_DIGITS   (ND),
        .STABLE_CYCLES(S),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seg_d     (seg_d),
        .an        (an),
        .hex_out   (hex_out),
        .digit_vld (digit_vld),
        .digit_err (digit_err),
        .upd       (upd),
        .frame_done(frame_done),
        .ghost_cnt (ghost_cnt)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_dec(input logic [6:0] s);
        for (int v = 0; v < 16; v++)
            if (PAT[v] == s) return {1'b1, 4'(v)};
        return 5'h00;
    endfunction

    // Reference model: a digit is captured once its legal sample has been
    // seen on S+1 consecutive edges (2-edge sync delay on the inputs).
    logic [6:0]      q_seg [2];
    logic [ND-1:0]   q_an  [2];
    logic [6:0]      l_seg;
    logic [ND-1:0]   l_an;
    int              dwell;
    logic [4*ND-1:0] m_hex;
    logic [ND-1:0]   m_vld, m_err, m_seen;
    logic            m_upd, m_frame;
    int              m_ghost;

    always @(posedge clk or negedge reset_n) begin : model
        logic [6:0]    cs;
        logic [ND-1:0] ca, sel;
        logic [4:0]    d;
        if (!reset_n) begin
            q_seg[0] = '0; q_seg[1] = '0;
            q_an[0]  = '0; q_an[1]  = '0;
            l_seg = '0; l_an = '0; dwell = 0;
            m_hex = '0; m_vld = '0; m_err = '0; m_seen = '0;
            m_upd = 1'b0; m_frame = 1'b0; m_ghost = 0;
        end else begin
            cs = q_seg[1];
            ca = q_an[1];
            q_seg[1] = q_seg[0]; q_an[1] = q_an[0];
            q_seg[0] = seg_d;    q_an[0] = an;
            sel = ~ca;
            m_upd = 1'b0;
            m_frame = 1'b0;
            if ($countones(sel) != 1) begin
                if (m_ghost < 255) m_ghost++;
                dwell = 0;
            end else if (cs == l_seg && ca == l_an) begin
                dwell++;
            end else begin
                dwell = 1;
            end
            l_seg = cs;
            l_an = ca;
            if (dwell == S + 1) begin
                m_upd = 1'b1;
                d = ref_dec(cs);
                for (int i = 0; i < ND; i++) begin
                    if (sel[i]) begin
                        if (d[4]) begin
                            m_hex[4*i +: 4] = d[3:0];
                            m_vld[i] = 1'b1;
                            m_err[i] = 1'b0;
                        end else begin
                            m_vld[i] = 1'b0;
                            m_err[i] = 1'b1;
                        end
                        m_seen[i] = 1'b1;
                    end
                end
                if (m_seen == '1) begin
                    m_frame = 1'b1;
                    m_seen = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cycle", {hex_out, digit_vld, digit_err, upd, frame_done, ghost_cnt},
              {m_hex, m_vld, m_err, m_upd, m_frame, 8'(m_ghost)});
        if (upd) upd_total++;
        if (frame_done) frame_total++;
    end

    // Drive one pattern for n clocks; report the edge of the first upd
    task automatic hold(input logic [6:0] s, input logic [ND-1:0] a,
                        input int n, input int exp_edge, input string name);
        int first;
        first = -1;
        @(negedge clk);
        seg_d = s;
        an = a;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (upd && first < 0) first = k;
        end
        check(name, first, exp_edge);
    endtask

    initial begin
        int u0, f0, g0;
        reset_n = 1'b1;
        seg_d = 7'h00;
        an = 4'hf;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hex", hex_out, 16'h0);
        check("rst_vld", digit_vld, 4'h0);
        check("rst_err", digit_err, 4'h0);
        check("rst_upd", upd, 1'b0);
        check("rst_frame", frame_done, 1'b0);
        check("rst_ghost", ghost_cnt, 8'h0);
        reset_n = 1'b1;

        u0 = upd_total;
        hold(7'h27, 4'b1110, 10, 6, "t1_edge");
        check("t1_nib", hex_out[3:0], 4'h7);
        check("t1_vld", digit_vld, 4'b0001);
        check("t1_err", digit_err, 4'b0000);
        check("t1_upd_once", upd_total - u0, 1);

        u0 = upd_total;
        f0 = frame_total;
        for (int r = 0; r < 2; r++) begin
            hold(7'h7f, 4'b1110, 8, 6, "scan_d0");
            hold(7'h5f, 4'b1101, 8, 6, "scan_d1");
            hold(7'h58, 4'b1011, 8, 6, "scan_d2");
            hold(7'h71, 4'b0111, 8, 6, "scan_d3");
        end
        check("scan_hex", hex_out, 16'hfca8);
        check("scan_frames", frame_total - f0, 2);
        check("scan_upds", upd_total - u0, 8);

        u0 = upd_total;
        hold(7'h00, 4'b1101, 8, 6, "blank_edge");
        check("blank_err", digit_err[1], 1'b1);
        check("blank_vld", digit_vld[1], 1'b0);
        check("blank_hex", hex_out[7:4], 4'ha);
        hold(7'h12, 4'b1101, 8, 6, "bad_edge");
        check("bad_err", digit_err[1], 1'b1);
        check("bad_hex", hex_out[7:4], 4'ha);
        check("bad_upds", upd_total - u0, 2);

        g0 = ghost_cnt;
        hold(7'h5f, 4'b1101, 2, -1, "gh_pre");
        hold(7'h5f, 4'b1100, 5, -1, "gh_multi");
        hold(7'h5f, 4'b1101, 8, 6, "gh_rehold");
        check("gh_delta", ghost_cnt - g0, 5);
        check("gh_vld", digit_vld[1], 1'b1);
        check("gh_err", digit_err[1], 1'b0);
        check("gh_hex", hex_out[7:4], 4'ha);

        for (int t = 0; t < 6; t++) begin
            hold(7'h06, 4'b1011, 3, -1, "tog_a");
            hold(7'h4f, 4'b1011, 3, -1, "tog_b");
        end
        hold(7'h6d, 4'b1011, 10, 6, "tog_settle");
        check("tog_hex", hex_out[11:8], 4'h5);

        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_all", {hex_out, digit_vld, digit_err, upd, frame_done, ghost_cnt},
              34'h0);
        @(negedge clk);
        reset_n = 1'b1;
        f0 = frame_total;
        hold(7'h3f, 4'b1110, 8, 6, "post_d0");
        hold(7'h06, 4'b1101, 8, 6, "post_d1");
        hold(7'h5b, 4'b1011, 8, 6, "post_d2");
        check("post_nofrm", frame_total - f0, 0);
        hold(7'h4f, 4'b0111, 8, 6, "post_d3");
        check("post_frame", frame_total - f0, 1);
        check("post_hex", hex_out, 16'h3210);

        hold(7'h00, 4'b1111, 300, -1, "idle");
        check("ghost_sat", ghost_cnt, 8'd255);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
